// File: rtl/trng_vn_collector.sv
// TRNG bit collector: decimates the synchronised ring-oscillator stream,
// optionally applies von Neumann debiasing, runs a repetition-count health
// check on raw samples and packs debiased bits into words for a valid/ready
// consumer.
module trng_vn_collector #(
  parameter int SAMPLE_CNT_W = 16,
  parameter int WORD_W       = 32,
  parameter int REP_LIMIT    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [SAMPLE_CNT_W-1:0] sample_cnt,
  input  logic                    vnc_bypass,
  input  logic                    rnd_bit,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic [WORD_W-1:0]       word_data,
  output logic                    ovf_err,
  output logic                    rep_err,
  input  logic                    err_clr
);

  localparam int PACK_W = $clog2(WORD_W);
  localparam int RUN_W  = $clog2(REP_LIMIT + 1);

  typedef enum logic {EMPTY, HAVE_FIRST} vn_state_t;

  // Run-length increment that sticks at REP_LIMIT.
  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] c);
    return (c == RUN_W'(REP_LIMIT)) ? c : c + RUN_W'(1);
  endfunction

  logic [SAMPLE_CNT_W-1:0] ivl_cnt;
  logic [SAMPLE_CNT_W-1:0] ivl_last;
  logic                    take;

  vn_state_t               vn_state, vn_next;
  logic                    first_bit, first_next;
  logic                    emit, emit_bit;

  logic [PACK_W-1:0]       pack_cnt;
  logic [WORD_W-1:0]       shreg, packed_word;
  logic                    word_done;
  logic                    ovf_set;

  logic [RUN_W-1:0]        run_cnt, run_next;
  logic                    last_raw;
  logic                    rep_set;

  // sample_cnt is read live; 0 behaves like 1 (sample every clock).
  // The >= compare keeps a shrinking interval from running the long way round.
  assign ivl_last = (sample_cnt == '0) ? '0 : sample_cnt - SAMPLE_CNT_W'(1);
  assign take     = enable && (ivl_cnt >= ivl_last);

  // Interval counter: runs only while enabled, wraps on the sampling clock.
  always_ff @(posedge clk) begin
    if (rst || !enable)
      ivl_cnt <= '0;
    else if (take)
      ivl_cnt <= '0;
    else
      ivl_cnt <= ivl_cnt + SAMPLE_CNT_W'(1);
  end

  // Von Neumann state register (first bit of the current pair).
  always_ff @(posedge clk) begin
    if (rst) begin
      vn_state  <= EMPTY;
      first_bit <= 1'b0;
    end else begin
      vn_state  <= vn_next;
      first_bit <= first_next;
    end
  end

  // Von Neumann pairing / bypass: decides whether a bit is emitted this cycle.
  always_comb begin
    vn_next    = vn_state;
    first_next = first_bit;
    emit       = 1'b0;
    emit_bit   = rnd_bit;
    if (!enable || vnc_bypass) begin
      vn_next = EMPTY;
      emit    = take;
    end else if (take) begin
      case (vn_state)
        EMPTY: begin
          first_next = rnd_bit;
          vn_next    = HAVE_FIRST;
        end
        HAVE_FIRST: begin
          vn_next = EMPTY;
          if (rnd_bit != first_bit) begin
            emit     = 1'b1;
            emit_bit = first_bit;
          end
        end
        default: vn_next = EMPTY;
      endcase
    end
  end

  // Word being assembled including this cycle's bit, and its completion.
  always_comb begin
    packed_word           = shreg;
    packed_word[pack_cnt] = emit_bit;
    word_done             = emit && (pack_cnt == PACK_W'(WORD_W - 1));
    ovf_set               = word_done && word_valid && !word_ready;
  end

  // Shift register and pack count; a partial word is discarded on disable.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      pack_cnt <= '0;
      shreg    <= '0;
    end else if (emit) begin
      if (word_done) begin
        pack_cnt <= '0;
        shreg    <= '0;
      end else begin
        pack_cnt <= pack_cnt + PACK_W'(1);
        shreg    <= packed_word;
      end
    end
  end

  // Single-entry output register; a same-cycle pop makes room for a new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_valid <= 1'b0;
      word_data  <= '0;
    end else if (word_done && (!word_valid || word_ready)) begin
      word_valid <= 1'b1;
      word_data  <= packed_word;
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
  end

  // Repetition count on raw samples; run_cnt==0 means no previous sample.
  always_comb begin
    run_next = run_cnt;
    if (take) begin
      if (run_cnt == '0 || rnd_bit != last_raw)
        run_next = RUN_W'(1);
      else
        run_next = run_sat_inc(run_cnt);
    end
    rep_set = take && (run_next == RUN_W'(REP_LIMIT));
  end

  // Run counter and previous raw sample.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      run_cnt  <= '0;
      last_raw <= 1'b0;
    end else begin
      run_cnt <= run_next;
      if (take)
        last_raw <= rnd_bit;
    end
  end

  // Sticky error flags: a set event wins over err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
      rep_err <= 1'b0;
    end else begin
      ovf_err <= ovf_set || (ovf_err && !err_clr);
      rep_err <= rep_set || (rep_err && !err_clr);
    end
  end

endmodule
